// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: cleans raw street A/B vehicle detectors into
// traffic-present flags TA/TB for the traffic-light controller.
// Each street gets an identical, independent channel: 2-flop synchronizer,
// debounce qualifier, gap-hold timer and saturating car counter.
// Optional feature macro: STUCK_DETECT_EN adds a sticky stuck-sensor fault
// per channel (fault_a/fault_b ports) without affecting TA/TB.

module tsc_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 50,
  parameter int CNT_W           = 8
`ifdef STUCK_DETECT_EN
  , parameter int STUCK_CYCLES  = 1000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             cnt_clr,
  output logic             t,
  output logic [CNT_W-1:0] car_cnt
`ifdef STUCK_DETECT_EN
  , output logic           fault
`endif
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {EMPTY, OCCUPIED, HOLD} state_t;

  state_t           state, state_n;
  logic             s1, s2;
  logic [DW-1:0]    deb, deb_n;
  logic [HW-1:0]    hold, hold_n;
  logic [CNT_W-1:0] cnt_n;
  logic             inc;

  // State, synchronizer and counter registers; t is registered from next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= EMPTY;
      deb     <= '0;
      hold    <= '0;
      car_cnt <= '0;
      t       <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      state   <= state_n;
      deb     <= deb_n;
      hold    <= hold_n;
      car_cnt <= cnt_n;
      t       <= (state_n != EMPTY);
    end
  end

  // Next-state: debounce in EMPTY, gap-hold timing in HOLD, count on qualification
  always_comb begin
    state_n = state;
    deb_n   = deb;
    hold_n  = hold;
    inc     = 1'b0;
    case (state)
      EMPTY: begin
        if (s2) begin
          if (deb == DEB_LAST) begin
            state_n = OCCUPIED;
            deb_n   = '0;
            inc     = 1'b1;
          end else begin
            deb_n = deb + DW'(1);
          end
        end else begin
          deb_n = '0;
        end
      end
      OCCUPIED: begin
        if (!s2) begin
          state_n = HOLD;
          hold_n  = HW'(1);
        end
      end
      HOLD: begin
        // a return of the detector inside the gap is the same car: no recount
        if (s2)                    state_n = OCCUPIED;
        else if (hold == HOLD_MAX) state_n = EMPTY;
        else                       hold_n  = hold + HW'(1);
      end
      default: state_n = EMPTY;
    endcase
    // clear wins over a same-edge qualification
    cnt_n = car_cnt;
    if (cnt_clr)                      cnt_n = '0;
    else if (inc && (car_cnt != '1))  cnt_n = car_cnt + CNT_W'(1);
  end

`ifdef STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
  logic [SW-1:0] stuck;

  // Count consecutive OCCUPIED edges; fault is sticky until reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      stuck <= '0;
      fault <= 1'b0;
    end else if (state == OCCUPIED) begin
      if (stuck == STUCK_LAST) fault <= 1'b1;
      if (stuck != STUCK_MAX)  stuck <= stuck + SW'(1);
    end else begin
      stuck <= '0;
    end
  end
`endif
endmodule

module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 50,
  parameter int CNT_W           = 8,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sa_raw,
  input  logic             sb_raw,
  input  logic             cnt_clr,
  output logic             TA,
  output logic             TB,
  output logic [CNT_W-1:0] car_cnt_a,
  output logic [CNT_W-1:0] car_cnt_b
`ifdef STUCK_DETECT_EN
  , output logic           fault_a
  , output logic           fault_b
`endif
);
  localparam int NUM_LANES = 2;

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_cfg
    $error("traffic_sensor_conditioner: cycle parameters must be >= 1");
  end

  logic [NUM_LANES-1:0]            raw, t;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
`ifdef STUCK_DETECT_EN
  logic [NUM_LANES-1:0]            fault;
  assign fault_a = fault[0];
  assign fault_b = fault[1];
`endif

  assign raw       = {sb_raw, sa_raw};
  assign TA        = t[0];
  assign TB        = t[1];
  assign car_cnt_a = cnt[0];
  assign car_cnt_b = cnt[1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
    tsc_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .CNT_W           (CNT_W)
`ifdef STUCK_DETECT_EN
      , .STUCK_CYCLES  (STUCK_CYCLES)
`endif
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw[i]),
      .cnt_clr (cnt_clr),
      .t       (t[i]),
      .car_cnt (cnt[i])
`ifdef STUCK_DETECT_EN
      , .fault (fault[i])
`endif
    );
  end
endmodule
